adder_arbiter: RTL and testbench

- Shares one pipelined chunked adder (`adder`, WIDTH/CHUNK parameters) between NUM_REQ requesters.
- Grants requests round-robin and holds the granted operands stable on the adder inputs.
- Drives the adder `en` for exactly the number of cycles the chunk carry chain needs to settle, then returns the full WIDTH+1-bit sum tagged with the requester id over a valid/ready response channel.

---
 rtl/adder_arbiter_pkg.sv | 23 ++
 rtl/adder.sv | 53 +++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/adder_arbiter.sv | 104 ++++++++++
 tb/tb_adder_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared math helpers and arbiter state encoding for the pipelined adder block.
// No logic; latency/backpressure not applicable.
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    function automatic int ceil_division(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adder.sv
// Chunked adder: ripple inside each chunk, registered carry between chunks.
// Sum settles after ceil(WIDTH/CHUNK) enabled edges; en=0 freezes the carry buffer.
module adder
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH:0]   out
);

    localparam int C = ceil_division(WIDTH, CHUNK);
    localparam bit EXACT = (WIDTH % CHUNK) == 0;

    logic [C-1:0]     carry_buffer;
    logic [C-1:0]     chunk_cout;
    logic [WIDTH-1:0] sum_bits;

    always_comb begin
        logic c;
        c          = 1'b0;
        sum_bits   = '0;
        chunk_cout = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // each chunk above the first takes its carry-in from the buffer
            if (i != 0 && (i % CHUNK) == 0) begin
                c = carry_buffer[i / CHUNK - 1];
            end
            sum_bits[i] = in1[i] ^ in2[i] ^ c;
            c = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
            if (((i + 1) % CHUNK) == 0 || i == WIDTH - 1) begin
                chunk_cout[i / CHUNK] = c;
            end
        end
    end

    // a full-width top chunk reports its carry-out from the register
    assign out = {(EXACT ? carry_buffer[C-1] : chunk_cout[C-1]), sum_bits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_buffer <= '0;
        end else if (en) begin
            carry_buffer <= chunk_cout;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req above ptr, with wrap.
// Zero latency; no backpressure (grant is all-zero when nothing requests).
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = max(1, $clog2(N))
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        grant = '0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            j = (int'(ptr) + off) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin share of one chunked adder among NUM_REQ requesters.
// Accept at t -> rsp_valid at t+C+1; result held stable while rsp_ready is low.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int CHUNK   = 3,
    parameter  int NUM_REQ = 3,
    localparam int IDW     = max(1, $clog2(NUM_REQ))
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH:0]           rsp_sum,
    output logic                     busy
);

    localparam int C  = ceil_division(WIDTH, CHUNK);
    localparam int CW = max(1, $clog2(C));

    arb_state_t           state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       id_q;
    logic [WIDTH-1:0]     op1, op2;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic                 add_en;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_adder (
        .clk (clk),
        .rst (rst),
        .en  (add_en),
        .in1 (op1),
        .in2 (op2),
        .out (rsp_sum)
    );

    always_comb begin
        state_nxt = state;
        add_en    = 1'b0;
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // no grant is visible while reset is held
                req_ready = rst ? '0 : grant;
                if (|req_valid) state_nxt = SETTLE;
            end
            SETTLE: begin
                add_en = 1'b1;
                if (cnt == CW'(C - 1)) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= IDW'(NUM_REQ - 1);
            id_q  <= '0;
            op1   <= '0;
            op2   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        op1  <= req_in1[grant_idx*WIDTH +: WIDTH];
                        op2  <= req_in2[grant_idx*WIDTH +: WIDTH];
                        ptr  <= grant_idx;
                        id_q <= grant_idx;
                        cnt  <= '0;
                    end
                end
                SETTLE:  cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_id = id_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: vector table over two adder configurations plus multi-cycle sequences.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [23:0] req_in1 = '0;
    logic [23:0] req_in2 = '0;
    logic        rsp_ready = 1'b1;

    logic [2:0]  a_req_ready, b_req_ready;
    logic        a_rsp_valid, b_rsp_valid;
    logic [1:0]  a_rsp_id, b_rsp_id;
    logic [8:0]  a_rsp_sum, b_rsp_sum;
    logic        a_busy, b_busy;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(8), .CHUNK(3), .NUM_REQ(3)) dut_a (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (a_req_ready),
        .req_in1 (req_in1), .req_in2 (req_in2),
        .rsp_valid (a_rsp_valid), .rsp_ready (rsp_ready),
        .rsp_id (a_rsp_id), .rsp_sum (a_rsp_sum), .busy (a_busy)
    );

    adder_arbiter #(.WIDTH(8), .CHUNK(4), .NUM_REQ(3)) dut_b (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (b_req_ready),
        .req_in1 (req_in1), .req_in2 (req_in2),
        .rsp_valid (b_rsp_valid), .rsp_ready (rsp_ready),
        .rsp_id (b_rsp_id), .rsp_sum (b_rsp_sum), .busy (b_busy)
    );

    logic       use_b = 1'b0;
    logic [2:0] m_rdy;
    logic       m_vld, m_busy;
    logic [1:0] m_id;
    logic [8:0] m_sum;
    assign m_rdy  = use_b ? b_req_ready : a_req_ready;
    assign m_vld  = use_b ? b_rsp_valid : a_rsp_valid;
    assign m_busy = use_b ? b_busy      : a_busy;
    assign m_id   = use_b ? b_rsp_id    : a_rsp_id;
    assign m_sum  = use_b ? b_rsp_sum   : a_rsp_sum;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    // one full transaction on the selected DUT with latency/busy checks
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp_sum, input int exp_lat, input bit chk_busy);
        int  k;
        bit  busy_ok;
        @(negedge clk);
        req_valid = 3'(1 << id);
        req_in1[id*8 +: 8] = a;
        req_in2[id*8 +: 8] = b;
        #1;
        k = 0;
        while (m_rdy == 3'b000 && k < 20) begin next_cyc(); k++; end
        chk("accept_ready", 32'(m_rdy), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        #1;
        k = 1;
        busy_ok = 1'b1;
        while (!m_vld && k < 20) begin
            if (!m_busy) busy_ok = 1'b0;
            next_cyc();
            k++;
        end
        chk("latency", 32'(k), 32'(exp_lat));
        chk("sum", 32'(m_sum), 32'(exp_sum));
        chk("rsp_id", 32'(m_id), 32'(id));
        if (chk_busy) chk("busy_during_op", 32'(busy_ok && m_busy), 32'd1);
        next_cyc();
        if (chk_busy) chk("busy_after_handshake", 32'(m_busy), 32'd0);
    endtask

    typedef struct {
        bit         sel;
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [8:0] s_hold;
        logic [1:0] id_hold;
        int rr_order[4];
        logic [8:0] rr_sum[3];

        // sel=0: CHUNK=3 (C=3), sel=1: CHUNK=4 (C=2, exact division)
        tbl[0]  = '{0, 0, 8'd200, 8'd100, 9'h12C};
        tbl[1]  = '{0, 1, 8'd255, 8'd1,   9'h100};
        tbl[2]  = '{0, 2, 8'd0,   8'd0,   9'h000};
        tbl[3]  = '{0, 0, 8'd85,  8'd170, 9'h0FF};
        tbl[4]  = '{0, 1, 8'd128, 8'd128, 9'h100};
        tbl[5]  = '{1, 0, 8'd255, 8'd255, 9'h1FE};
        tbl[6]  = '{1, 0, 8'd0,   8'd0,   9'h000};
        tbl[7]  = '{1, 0, 8'd255, 8'd1,   9'h100};
        tbl[8]  = '{1, 0, 8'd0,   8'd0,   9'h000};
        tbl[9]  = '{1, 1, 8'd15,  8'd1,   9'h010};
        tbl[10] = '{1, 2, 8'd240, 8'd16,  9'h100};

        // reset values, with requests present while reset is held
        req_valid = 3'b111;
        #12;
        chk("rst_busy_a", 32'(a_busy), 32'd0);
        chk("rst_rsp_valid_a", 32'(a_rsp_valid), 32'd0);
        chk("rst_req_ready_a", 32'(a_req_ready), 32'd0);
        chk("rst_rsp_id_a", 32'(a_rsp_id), 32'd0);
        chk("rst_rsp_sum_a", 32'(a_rsp_sum), 32'd0);
        chk("rst_busy_b", 32'(b_busy), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            use_b = tbl[i].sel;
            do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].sel ? 3 : 4, 1'b1);
        end
        use_b = 1'b0;

        // round-robin with all requesters continuously valid
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        rr_order = '{0, 1, 2, 0};
        rr_sum   = '{9'd11, 9'd24, 9'd37};
        req_in1  = {8'd30, 8'd20, 8'd10};
        req_in2  = {8'd7,  8'd4,  8'd1};
        req_valid = 3'b111;
        #1;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            while (a_req_ready == 3'b000 && k < 20) begin next_cyc(); k++; end
            chk("rr_grant", 32'(a_req_ready), 32'(1 << rr_order[n]));
            next_cyc();
            chk("rr_pulse_one_cycle", 32'(a_req_ready), 32'd0);
            k = 0;
            while (!a_rsp_valid && k < 20) begin next_cyc(); k++; end
            chk("rr_rsp_id", 32'(a_rsp_id), 32'(rr_order[n]));
            chk("rr_rsp_sum", 32'(a_rsp_sum), 32'(rr_sum[rr_order[n]]));
            if (n == 3) begin
                @(negedge clk);
                req_valid = '0;
                #1;
            end else begin
                next_cyc();
            end
        end
        next_cyc();

        // backpressure: response held for 5 cycles while another request waits
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 3'b010;
        req_in1[15:8] = 8'd100;
        req_in2[15:8] = 8'd60;
        #1;
        k = 0;
        while (a_req_ready == 3'b000 && k < 20) begin next_cyc(); k++; end
        chk("bp_accept", 32'(a_req_ready), 32'b010);
        @(negedge clk);
        req_valid = 3'b001;
        req_in1[7:0] = 8'd1;
        req_in2[7:0] = 8'd2;
        #1;
        k = 0;
        while (!a_rsp_valid && k < 20) begin next_cyc(); k++; end
        s_hold  = a_rsp_sum;
        id_hold = a_rsp_id;
        chk("bp_sum", 32'(s_hold), 32'h0A0);
        chk("bp_id", 32'(id_hold), 32'd1);
        for (int c = 0; c < 5; c++) begin
            next_cyc();
            chk("bp_valid_held", 32'(a_rsp_valid), 32'd1);
            chk("bp_sum_stable", 32'(a_rsp_sum), 32'(s_hold));
            chk("bp_id_stable", 32'(a_rsp_id), 32'(id_hold));
            chk("bp_no_ready", 32'(a_req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_valid_before_edge", 32'(a_rsp_valid), 32'd1);
        next_cyc();
        chk("bp_idle_busy", 32'(a_busy), 32'd0);
        chk("bp_idle_ready", 32'(a_req_ready), 32'b001);
        @(negedge clk);
        req_valid = '0;
        #1;
        k = 0;
        while (!a_rsp_valid && k < 20) begin next_cyc(); k++; end
        chk("bp_next_sum", 32'(a_rsp_sum), 32'd3);
        chk("bp_next_id", 32'(a_rsp_id), 32'd0);
        next_cyc();
        next_cyc();

        // reset during the second SETTLE cycle
        @(negedge clk);
        req_valid = 3'b001;
        req_in1[7:0] = 8'd7;
        req_in2[7:0] = 8'd9;
        #1;
        k = 0;
        while (a_req_ready == 3'b000 && k < 20) begin next_cyc(); k++; end
        chk("mid_rst_accept", 32'(a_req_ready), 32'b001);
        @(negedge clk);
        req_valid = '0;
        next_cyc();
        chk("mid_rst_settling", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_valid", 32'(a_rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            next_cyc();
            if (a_rsp_valid) k++;
        end
        chk("mid_rst_no_response", 32'(k), 32'd0);
        do_op(0, 8'd7, 8'd9, 9'd16, 4, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
